// File: rtl/shadow_memory_ctrl.sv
// Shadow-memory controller: copies a boot ROM image into a window of an
// on-chip RAM after every reset or copy request, then serves single-word
// read/write requests from the memory bridge with a one-cycle acknowledge.
//
// state | meaning
// ------+-----------------------------------------------------------------
// COPY  | ROM->RAM copy running, Busy=1, bridge requests ignored
// READY | idle, accepts a bridge request or a copy request
// ACK   | Memory_Ack high for this cycle, RdData valid for reads
module shadow_memory_ctrl #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int ROM_WORDS     = 256,
  parameter int SHADOW_BASE   = 0,
  parameter bit WRITE_PROTECT = 1'b0,
  localparam int ROM_AW       = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              ResetReq,
  input  logic              MemBridge_Load,
  input  logic              MemBridge_Direction,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              Memory_Ack,
  output logic              ProtErr,
  output logic              Busy,
  output logic              CopyDone,
  output logic [ROM_AW-1:0] RomAddr,
  input  logic [DATA_W-1:0] RomData
);

  localparam int CNT_W = (ROM_WORDS > 1) ? $clog2(ROM_WORDS + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ROM_WORDS);
  localparam logic [ADDR_W:0]   WIN_LO   = (ADDR_W + 1)'(SHADOW_BASE);
  localparam logic [ADDR_W:0]   WIN_HI   = (ADDR_W + 1)'(SHADOW_BASE + ROM_WORDS);

  // Parameter sanity: the window must fit in the RAM without wrapping.
  if (ROM_WORDS < 1) begin : g_bad_rom_words
    $error("shadow_memory_ctrl: ROM_WORDS must be at least 1");
  end
  if ((longint'(SHADOW_BASE) + longint'(ROM_WORDS)) > (longint'(1) << ADDR_W)) begin : g_bad_window
    $error("shadow_memory_ctrl: shadow window exceeds RAM depth");
  end

  typedef enum logic [1:0] {
    COPY  = 2'd0,
    READY = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              reset_pend;
  logic [DATA_W-1:0] ram [0:(2**ADDR_W)-1];

  logic              accept;
  logic              in_window;
  logic              drop;
  logic              copy_we;
  logic              host_we;
  logic [ADDR_W-1:0] copy_addr;

  // Request decode; a copy request (fresh or deferred from ACK) beats a Load.
  always_comb begin
    accept    = (state == READY) && !ResetReq && !reset_pend && MemBridge_Load;
    in_window = ({1'b0, Addr} >= WIN_LO) && ({1'b0, Addr} < WIN_HI);
    drop      = WRITE_PROTECT && in_window;
    copy_we   = (state == COPY) && (cnt != '0);
    host_we   = accept && MemBridge_Direction && !drop;
    copy_addr = ADDR_W'(SHADOW_BASE) + ADDR_W'(cnt) - ADDR_W'(1);
  end

  // RomData lags RomAddr by one cycle, so word cnt-1 lands while cnt is shown.
  assign RomAddr = cnt[ROM_AW-1:0];

  // RAM array: no reset; a reset edge suppresses any write in flight.
  always_ff @(posedge Clock) begin
    if (Reset_n) begin
      if (copy_we) begin
        ram[copy_addr] <= RomData;
      end else if (host_we) begin
        ram[Addr] <= WrData;
      end
    end
  end

  // Control FSM with registered status and read data.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state      <= COPY;
      cnt        <= '0;
      reset_pend <= 1'b0;
      Busy       <= 1'b1;
      Memory_Ack <= 1'b0;
      ProtErr    <= 1'b0;
      CopyDone   <= 1'b0;
      RdData     <= '0;
    end else begin
      Memory_Ack <= 1'b0;
      ProtErr    <= 1'b0;
      CopyDone   <= 1'b0;
      case (state)
        COPY: begin
          if (cnt == CNT_LAST) begin
            state    <= READY;
            Busy     <= 1'b0;
            CopyDone <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        READY: begin
          if (ResetReq || reset_pend) begin
            state      <= COPY;
            cnt        <= '0;
            Busy       <= 1'b1;
            reset_pend <= 1'b0;
          end else if (MemBridge_Load) begin
            state      <= ACK;
            Memory_Ack <= 1'b1;
            ProtErr    <= MemBridge_Direction && drop;
            if (!MemBridge_Direction) begin
              RdData <= ram[Addr];
            end
          end
        end
        ACK: begin
          // A copy request here waits until the acknowledge has completed.
          if (ResetReq) begin
            reset_pend <= 1'b1;
          end
          state <= READY;
        end
        default: begin
          state <= COPY;
          cnt   <= '0;
          Busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
